// File: rtl/seg7_scan_display.sv
// Multiplexed seven-segment scanner: DIGITS anodes, shared cathodes,
// per-digit enable, leading-zero blanking, 16-level PWM, frame snapshot.
// Ports: i_clk, i_nReset (sync, active-low), i_value (4 bits/digit),
//   i_dots, i_digitEnable, i_blankLeadingZeros, i_brightness (0..15),
//   o_cathodes {dp,g..a} active-low, o_anodes active-low, o_frameDone.
module seg7_scan_display #(
    parameter int DIGITS      = 8,
    parameter int REFRESH_DIV = 5000
) (
    input  logic                  i_clk,
    input  logic                  i_nReset,
    input  logic [4*DIGITS-1:0]   i_value,
    input  logic [DIGITS-1:0]     i_dots,
    input  logic [DIGITS-1:0]     i_digitEnable,
    input  logic                  i_blankLeadingZeros,
    input  logic [3:0]            i_brightness,
    output logic [7:0]            o_cathodes,
    output logic [DIGITS-1:0]     o_anodes,
    output logic                  o_frameDone
);

    localparam int SUB_DIV = REFRESH_DIV / 16;
    localparam int CNT_W   = $clog2(REFRESH_DIV);
    localparam int SUB_W   = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
    localparam int DIG_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [CNT_W-1:0]    slot_q, slot_d;
    logic [SUB_W-1:0]    sub_q, sub_d;
    logic [3:0]          phase_q, phase_d;
    logic [DIG_W-1:0]    digit_q, digit_d;
    logic [4*DIGITS-1:0] val_q, val_d;
    logic [DIGITS-1:0]   dots_q, dots_d;
    logic [DIGITS-1:0]   en_q, en_d;
    logic                blank_q, blank_d;
    logic [3:0]          bright_q, bright_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [7:0]          cat_q, cat_d;
    logic                done_q, done_d;

    logic                frame_start;
    logic                last_slot;
    logic                last_sub;
    logic                last_digit;
    logic [3:0]          nib;
    logic                dot;
    logic                en_cur;
    logic                blank_cur;
    logic                zero_above;
    logic [DIGITS-1:0]   blank_mask;
    logic [6:0]          seg;

    // Counters: slot position, phase sub-counter, digit index.
    always_comb begin
        last_slot   = (slot_q == CNT_W'(REFRESH_DIV - 1));
        last_sub    = (sub_q == SUB_W'(SUB_DIV - 1));
        last_digit  = (digit_q == DIG_W'(DIGITS - 1));
        frame_start = (slot_q == '0) && (digit_q == '0);

        slot_d  = last_slot ? '0 : slot_q + CNT_W'(1);
        sub_d   = (last_slot || last_sub) ? '0 : sub_q + SUB_W'(1);
        phase_d = phase_q;
        if (last_slot)
            phase_d = '0;
        else if (last_sub)
            phase_d = phase_q + 4'd1;
        digit_d = digit_q;
        if (last_slot)
            digit_d = last_digit ? '0 : digit_q + DIG_W'(1);

        done_d = last_slot && last_digit;
    end

    // Snapshot: the frame-start cycle already drives from the new
    // inputs, so the whole frame shows one consistent value.
    always_comb begin
        val_d    = frame_start ? i_value             : val_q;
        dots_d   = frame_start ? i_dots              : dots_q;
        en_d     = frame_start ? i_digitEnable       : en_q;
        blank_d  = frame_start ? i_blankLeadingZeros : blank_q;
        bright_d = frame_start ? i_brightness        : bright_q;
    end

    // Leading-zero mask, scanned from the most significant digit down;
    // disabled digits are treated as zero.
    always_comb begin
        zero_above = 1'b1;
        blank_mask = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above &&
                (!en_d[k] || (val_d[4*k +: 4] == 4'h0));
            blank_mask[k] = blank_d && zero_above && (k != 0);
        end
    end

    always_comb begin
        nib       = 4'h0;
        dot       = 1'b0;
        en_cur    = 1'b0;
        blank_cur = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (DIG_W'(k) == digit_q) begin
                nib       = val_d[4*k +: 4];
                dot       = dots_d[k];
                en_cur    = en_d[k];
                blank_cur = blank_mask[k];
            end
        end

        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        if (blank_cur)
            seg = 7'h7F;

        cat_d = {~dot, seg};
        an_d  = '1;
        if (en_cur && (phase_q < bright_d))
            an_d[digit_q] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_nReset) begin
            slot_q   <= '0;
            sub_q    <= '0;
            phase_q  <= '0;
            digit_q  <= '0;
            val_q    <= '0;
            dots_q   <= '0;
            en_q     <= '0;
            blank_q  <= 1'b0;
            bright_q <= '0;
            an_q     <= '1;
            cat_q    <= 8'hFF;
            done_q   <= 1'b0;
        end else begin
            slot_q   <= slot_d;
            sub_q    <= sub_d;
            phase_q  <= phase_d;
            digit_q  <= digit_d;
            val_q    <= val_d;
            dots_q   <= dots_d;
            en_q     <= en_d;
            blank_q  <= blank_d;
            bright_q <= bright_d;
            an_q     <= an_d;
            cat_q    <= cat_d;
            done_q   <= done_d;
        end
    end

    assign o_anodes    = an_q;
    assign o_cathodes  = cat_q;
    assign o_frameDone = done_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display (DIGITS=4, REFRESH_DIV=32): directed and
// random stimulus against a cycle-position reference model.
module tb_seg7_scan_display;

    localparam int D  = 4;
    localparam int RD = 32;
    localparam int FRAME = D * RD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] val = '0;
    logic [3:0]  dots = '0;
    logic [3:0]  en = '0;
    logic        bl = 1'b0;
    logic [3:0]  br = '0;
    logic [7:0]  cath;
    logic [3:0]  an;
    logic        fd;

    seg7_scan_display #(.DIGITS(D), .REFRESH_DIV(RD)) dut (
        .i_clk              (clk),
        .i_nReset           (rst_n),
        .i_value            (val),
        .i_dots             (dots),
        .i_digitEnable      (en),
        .i_blankLeadingZeros(bl),
        .i_brightness       (br),
        .o_cathodes         (cath),
        .o_anodes           (an),
        .o_frameDone        (fd)
    );

    always #5 clk = ~clk;

    logic [7:0] seg_tab [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    int          n_cmp = 0;
    int          n_bad = 0;
    int          t = 0;
    int          fd_seen = 0;
    logic [15:0] s_val;
    logic [3:0]  s_dots, s_en, s_br;
    logic        s_bl;

    // One clock: predict from cycles elapsed since reset release and
    // the snapshot taken at each frame start, then check after the edge.
    task automatic tick();
        logic [3:0]  e_an;
        logic [7:0]  e_ca;
        logic        e_fd;
        logic [15:0] mv;
        int pos, dg, ph;
        if (!rst_n) begin
            e_an = 4'hF;
            e_ca = 8'hFF;
            e_fd = 1'b0;
            t = 0;
        end else begin
            pos = t % FRAME;
            if (pos == 0) begin
                s_val = val; s_dots = dots; s_en = en;
                s_bl = bl; s_br = br;
            end
            dg = pos / RD;
            ph = (pos % RD) / (RD / 16);
            e_an = 4'hF;
            if (s_en[dg] && ph < int'(s_br))
                e_an[dg] = 1'b0;
            mv = '0;
            for (int i = 0; i < D; i++)
                if (s_en[i]) mv[4*i +: 4] = s_val[4*i +: 4];
            e_ca = seg_tab[s_val[4*dg +: 4]];
            if (s_bl && dg != 0 && (mv >> (4 * dg)) == 16'h0)
                e_ca = 8'h7F;
            e_ca[7] = ~s_dots[dg];
            e_fd = (pos == FRAME - 1);
            t++;
        end
        @(posedge clk);
        #1;
        n_cmp += 3;
        if (fd === 1'b1) fd_seen++;
        assert (an === e_an) else begin
            n_bad++;
            $error("FAIL anodes t=%0d: got %h expected %h", t, an, e_an);
        end
        assert (cath === e_ca) else begin
            n_bad++;
            $error("FAIL cathodes t=%0d: got %h expected %h", t, cath, e_ca);
        end
        assert (fd === e_fd) else begin
            n_bad++;
            $error("FAIL frameDone t=%0d: got %b expected %b", t, fd, e_fd);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int fd_before;
        // Reset with the first display pattern on the inputs
        val = 16'h1234; en = 4'hF; br = 4'd15; dots = 4'h0; bl = 1'b0;
        rst_n = 1'b0;
        run(5);
        rst_n = 1'b1;
        run(40);
        // Mid-frame change is held off until the next frame start
        val = 16'hABCD;
        run(2 * FRAME - 40);
        // Blanking with dp on the blanked top digit, then without
        val = 16'h0050; bl = 1'b1; dots = 4'b1000;
        run(FRAME);
        bl = 1'b0;
        run(FRAME);
        // Brightness levels
        br = 4'd4;
        run(FRAME);
        br = 4'd0;
        run(FRAME);
        // Partial enable, frame period unchanged
        br = 4'd9; en = 4'b0101; val = 16'h7008; bl = 1'b1;
        run(FRAME);
        // Reset at digit 2, slot 10, then one full frame to check the
        // restart and the first frameDone after release
        en = 4'hF; run(FRAME - (t % FRAME));
        run(2 * RD + 10);
        rst_n = 1'b0;
        run(2);
        rst_n = 1'b1;
        fd_before = fd_seen;
        run(FRAME);
        n_cmp++;
        assert (fd_seen == fd_before + 1) else begin
            n_bad++;
            $error("FAIL restart_fd: got %0d expected %0d",
                   fd_seen - fd_before, 1);
        end
        // Randomised inputs with occasional resets
        for (int i = 0; i < 20 * FRAME; i++) begin
            if ($urandom_range(0, 7) == 0) val = 16'($urandom);
            if ($urandom_range(0, 3) == 0)
                val[15:8] = ($urandom_range(0, 1) == 0) ? 8'h00 : val[15:8];
            if ($urandom_range(0, 15) == 0) dots = 4'($urandom);
            if ($urandom_range(0, 15) == 0) en = 4'($urandom);
            if ($urandom_range(0, 15) == 0) bl = 1'($urandom);
            if ($urandom_range(0, 15) == 0) br = 4'($urandom);
            rst_n = ($urandom_range(0, 399) != 0);
            tick();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
